shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shift_step.sv | 40 ++++
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer: FSM state encoding and shift
// direction encoding. Imported by the top and by the per-step datapath.
package shift_sequencer_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // shift direction encoding (matches the shift_dir input)
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// shift_step: combinational single-step shifter/rotator.
// Ports:
//   data_i  [W-1:0]  word to shift
//   dist_i  [DW-1:0] distance for this step (0..S, always < W)
//   dir_i            1 = right, 0 = left
//   wrap_i           1 = rotate, 0 = logical shift with zero fill
//   data_o  [W-1:0]  shifted word
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int W  = 8,
  parameter int DW = 2
) (
  input  logic [W-1:0]  data_i,
  input  logic [DW-1:0] dist_i,
  input  logic          dir_i,
  input  logic          wrap_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] shr;
  logic [W-1:0] shl;
  logic [W-1:0] wrap_r;
  logic [W-1:0] wrap_l;

  always_comb begin
    shr = data_i >> dist_i;
    shl = data_i << dist_i;
    // Bits pushed out one end re-enter at the other; a zero distance shifts
    // by W, which clears the wrapped part and leaves the word unchanged.
    wrap_r = data_i << (W - int'(dist_i));
    wrap_l = data_i >> (W - int'(dist_i));
    if (dir_i == DIR_RIGHT) begin
      data_o = wrap_i ? (shr | wrap_r) : shr;
    end else begin
      data_o = wrap_i ? (shl | wrap_l) : shl;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one word plus a shift amount, then shifts or
// rotates it by at most STEP_BITS per clock until the full amount is applied,
// and presents the result under a valid/ready handshake.
// Ports:
//   clk, rst (sync, active high)
//   in_valid / in_ready        request handshake
//   data_in, shift_amount, shift_dir (1=right), wrap (1=rotate)
//   out_valid / out_ready      result handshake, data_out is registered
//   busy                       high whenever not idle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter string ARCHITECTURE     = "BEHAVIORAL",
  parameter int    INPUT_DATA_WIDTH = 8,
  parameter int    STEP_BITS        = 2,
  parameter int    AMOUNT_WIDTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0] data_in,
  input  logic [AMOUNT_WIDTH-1:0]     shift_amount,
  input  logic                        shift_dir,
  input  logic                        wrap,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INPUT_DATA_WIDTH-1:0] data_out,
  output logic                        busy
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int A  = AMOUNT_WIDTH;
  localparam int DW = $clog2(STEP_BITS + 1);

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav

    logic [1:0]    state_q, state_d;
    logic [A-1:0]  rem_q, rem_d;
    logic [W-1:0]  work_q, work_d;
    logic          dir_q, dir_d;
    logic          wrap_q, wrap_d;
    logic [DW-1:0] step;
    logic [W-1:0]  stepped;

    // step = min(remaining, STEP_BITS)
    always_comb begin
      if (int'(rem_q) < STEP_BITS) step = DW'(rem_q);
      else                         step = DW'(STEP_BITS);
    end

    shift_step #(.W(W), .DW(DW)) u_step (
      .data_i (work_q),
      .dist_i (step),
      .dir_i  (dir_q),
      .wrap_i (wrap_q),
      .data_o (stepped)
    );

    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      work_d  = work_q;
      dir_d   = dir_q;
      wrap_d  = wrap_q;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_d  = data_in;
            rem_d   = shift_amount;
            dir_d   = shift_dir;
            wrap_d  = wrap;
            state_d = (shift_amount != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          work_d = stepped;
          rem_d  = rem_q - A'(step);
          if (rem_d == '0) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        rem_q   <= '0;
        work_q  <= '0;
        dir_q   <= DIR_LEFT;
        wrap_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        work_q  <= work_d;
        dir_q   <= dir_d;
        wrap_q  <= wrap_d;
      end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign data_out  = work_q;

  end else begin : g_placeholder
    // VIRTEX5 / VIRTEX6 implementations are not provided; outputs are tied off.
    assign in_ready  = 1'b0;
    assign out_valid = 1'b0;
    assign busy      = 1'b0;
    assign data_out  = '0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [3:0] shift_amount;
  logic       shift_dir;
  logic       wrap;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer #(
    .ARCHITECTURE     ("BEHAVIORAL"),
    .INPUT_DATA_WIDTH (8),
    .STEP_BITS        (2),
    .AMOUNT_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .shift_dir    (shift_dir),
    .wrap         (wrap),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs every cycle while busy, then measure
  // edges from the accepting edge to out_valid and check the result.
  task automatic run_req(input string tag, input logic [7:0] d, input logic [3:0] amt,
                         input logic dir, input logic wr, input logic [7:0] exp_d,
                         input int exp_lat);
    int edges;
    @(negedge clk);
    data_in = d; shift_amount = amt; shift_dir = dir; wrap = wr;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    edges = 1;
    while (!out_valid && edges < 40) begin
      data_in = 8'($urandom); shift_amount = 4'($urandom);
      shift_dir = 1'($urandom); wrap = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check_eq({tag, " latency"}, 32'(edges), 32'(exp_lat));
    check_eq({tag, " data"}, 32'(data_out), 32'(exp_d));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check_eq({tag, " back to idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1; in_valid = 1'b0; data_in = 8'h00; shift_amount = 4'd0;
    shift_dir = 1'b0; wrap = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset in_ready", 32'(in_ready), 32'd1);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset data_out", 32'(data_out), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_req("shr B4 3",   8'hB4, 4'd3,  1'b1, 1'b0, 8'h16, 3);
    run_req("shl B4 3",   8'hB4, 4'd3,  1'b0, 1'b0, 8'hA0, 3);
    run_req("rol 81 1",   8'h81, 4'd1,  1'b0, 1'b1, 8'h03, 2);
    run_req("ror 01 9",   8'h01, 4'd9,  1'b1, 1'b1, 8'h80, 6);
    run_req("shr 01 9",   8'h01, 4'd9,  1'b1, 1'b0, 8'h00, 6);
    run_req("shr 5A 0",   8'h5A, 4'd0,  1'b1, 1'b0, 8'h5A, 1);
    run_req("shl 5A 0",   8'h5A, 4'd0,  1'b0, 1'b1, 8'h5A, 1);
    run_req("rol 96 15",  8'h96, 4'd15, 1'b0, 1'b1, 8'h4B, 9);
    run_req("shl FF 8",   8'hFF, 4'd8,  1'b0, 1'b0, 8'h00, 5);
    run_req("ror C3 8",   8'hC3, 4'd8,  1'b1, 1'b1, 8'hC3, 5);

    // Hold in DONE with out_ready low while a new request is offered.
    @(negedge clk);
    data_in = 8'hB4; shift_amount = 4'd3; shift_dir = 1'b1; wrap = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h77; shift_amount = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    held = data_out;
    check_eq("hold reached done", 32'(out_valid), 32'd1);
    check_eq("hold result", 32'(held), 32'h16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("hold data_out", 32'(data_out), 32'(held));
      check_eq("hold out_valid", 32'(out_valid), 32'd1);
      check_eq("hold in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset in the middle of a long shift.
    @(negedge clk);
    data_in = 8'hFF; shift_amount = 4'd15; shift_dir = 1'b1; wrap = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid shift busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst mid busy", 32'(busy), 32'd0);
    check_eq("rst mid out_valid", 32'(out_valid), 32'd0);
    check_eq("rst mid data_out", 32'(data_out), 32'd0);
    check_eq("rst mid in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    run_req("shr F0 4", 8'hF0, 4'd4, 1'b1, 1'b0, 8'h0F, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
